axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares one AXI4-Lite read port (AR/R channels) between the instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core.
- Sits between the two masters and the memory/crossbar slave.
- Arbitration is round-robin, with one transaction in flight at a time.
- A response timeout returns SLVERR to the master so a hung slave cannot deadlock the core.
- The write path does not pass through this block.

Parameters:
TIMEOUT, 256, cycles waiting for s_rvalid before a synthetic SLVERR is returned; 0 disables the timeout.
CNT_W, 16, width of the timeout counter; TIMEOUT must be less than 2^CNT_W.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
ifu_araddr  input  32  IFU read address
ifu_arvalid  input  1  IFU address valid
ifu_arready  output  1  IFU address accepted
ifu_rdata  output  32  read data to IFU
ifu_rresp  output  2  read response to IFU
ifu_rvalid  output  1  IFU read data valid
ifu_rready  input  1  IFU ready for data
lsu_araddr  input  32  LSU read address
lsu_arvalid  input  1  LSU address valid
lsu_arready  output  1  LSU address accepted
lsu_rdata  output  32  read data to LSU
lsu_rresp  output  2  read response to LSU
lsu_rvalid  output  1  LSU read data valid
lsu_rready  input  1  LSU ready for data
s_araddr  output  32  address to slave
s_arvalid  output  1  address valid to slave
s_arready  input  1  slave accepts address
s_rdata  input  32  slave read data
s_rresp  input  2  slave response
s_rvalid  input  1  slave data valid
s_rready  output  1  ready to slave

Behaviour:
- Registered state: state, owner, last_owner, counter.
  - state is one of IDLE, ADDR, DATA, ERR, DRAIN.
  - owner is IFU=0 or LSU=1.
  - counter is CNT_W bits wide.
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=IFU, last_owner=LSU, counter=0.
  - All valid/ready outputs are 0 immediately.
  - s_araddr, rdata and rresp outputs are 0.
  - An in-flight transaction is abandoned; masters are reset by the same signal.
- All outputs are combinational functions of state, owner and inputs.
  - The non-owning master always sees arready=0 and rvalid=0.
  - Its rdata and rresp are 0.
- IDLE:
  - Only one master valid: owner<=that master, go to ADDR.
  - Both valid: owner<=!last_owner, go to ADDR. At the first tie after reset, IFU wins.
  - Neither valid: stay in IDLE.
  - Latency is 1 cycle from arvalid to s_arvalid.
- ADDR:
  - Drive s_araddr=owner araddr and s_arvalid=owner arvalid.
  - Owner arready=s_arready.
  - When s_arvalid&&s_arready: go to DATA, counter<=0.
  - No timeout applies in ADDR.
- DATA:
  - Owner rdata/rresp/rvalid are driven from s_rdata/s_rresp/s_rvalid; s_rready=owner rready.
  - On s_rvalid&&s_rready: last_owner<=owner, go to IDLE.
  - While s_rvalid=0: counter increments.
  - Timeout: when TIMEOUT!=0 and counter==TIMEOUT-1 with s_rvalid=0, go to ERR.
  - While s_rvalid=1 but the owner is not ready: counter holds; no timeout.
- ERR:
  - Owner sees rvalid=1, rresp=2'b10, rdata=0; s_rready=0.
  - On owner rready: last_owner<=owner, go to DRAIN.
- DRAIN:
  - s_rready=1; both masters see rvalid=0, and both see arready=0.
  - On s_rvalid: discard the beat, go to IDLE.
  - DRAIN has no timeout; the stale beat must be absorbed before any new grant.
- A new grant is never issued in the same cycle as an R handshake. Minimum turnaround is one IDLE cycle.
- The block never reorders or merges transactions, and never alters a slave rresp or rdata.
- s_arvalid drops only after the AR handshake. A master that deasserts arvalid in ADDR is an AXI violation and is not checked.

Test Plan:
- Single IFU read:
  - Stimulus: ifu_arvalid=1, addr 0x8000_0000; slave arready on the 2nd cycle; rdata 0xDEADBEEF, rresp 0.
  - Required: s_araddr=0x8000_0000 one cycle after request; ifu_rdata=0xDEADBEEF; lsu_rvalid never 1; state returns to IDLE.
- Simultaneous requests, three rounds, both arvalid held high:
  - Required: grant order IFU, LSU, IFU.
  - s_araddr alternates 0x8000_0000 / 0x8000_1000.
  - No overlap of s_arvalid with an outstanding R.
- Back-pressure:
  - Stimulus: slave rvalid=1 while lsu_rready=0 for 5 cycles, TIMEOUT=4.
  - Required: no timeout fires; data is delivered unchanged when rready rises.
- Timeout:
  - Stimulus: TIMEOUT=4; slave accepts AR and never asserts rvalid.
  - Required: owner sees rvalid=1, rresp=2'b10, rdata=0, 4 cycles after the AR handshake.
  - Then a late s_rvalid beat is swallowed in DRAIN (s_rready=1); the next IFU request is granted only after that.
- Async reset in DATA:
  - Stimulus: assert reset=0 mid-cycle in DATA.
  - Required: s_rready, s_arvalid and all master rvalid/arready go to 0 without a clock edge.
  - After release, the first tie is granted to IFU.
- Slave error passthrough:
  - Stimulus: s_rresp=2'b11.
  - Required: lsu_rresp=2'b11 delivered unchanged.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read port between IFU and LSU,
// one transaction in flight, with a response timeout that returns SLVERR.
//
// state | meaning
// IDLE  | no transaction; pick the next owner
// ADDR  | forwarding owner AR to the slave
// DATA  | waiting for / forwarding the slave R beat
// ERR   | synthetic SLVERR presented to the owner
// DRAIN | absorbing the late slave beat of a timed-out read
module axi_read_arbiter #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DRAIN} state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam bit   TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] own_araddr;
    logic        own_arvalid;
    logic        own_rready;

    assign own_araddr  = owner_q ? lsu_araddr  : ifu_araddr;
    assign own_arvalid = owner_q ? lsu_arvalid : ifu_arvalid;
    assign own_rready  = owner_q ? lsu_rready  : ifu_rready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ifu_arvalid && lsu_arvalid) begin
                    owner_d = ~last_q;
                    state_d = ADDR;
                end else if (ifu_arvalid) begin
                    owner_d = OWN_IFU;
                    state_d = ADDR;
                end else if (lsu_arvalid) begin
                    owner_d = OWN_LSU;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_araddr  = own_araddr;
                s_arvalid = own_arvalid;
                if (owner_q) lsu_arready = s_arready;
                else         ifu_arready = s_arready;
                if (own_arvalid && s_arready) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                s_rready = own_rready;
                if (owner_q) begin
                    lsu_rvalid = s_rvalid;
                    lsu_rdata  = s_rdata;
                    lsu_rresp  = s_rresp;
                end else begin
                    ifu_rvalid = s_rvalid;
                    ifu_rdata  = s_rdata;
                    ifu_rresp  = s_rresp;
                end
                // a pending beat stalled by the master freezes the timer
                if (s_rvalid) begin
                    if (own_rready) begin
                        last_d  = owner_q;
                        state_d = IDLE;
                    end
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                if (owner_q) begin
                    lsu_rvalid = 1'b1;
                    lsu_rresp  = 2'b10;
                end else begin
                    ifu_rvalid = 1'b1;
                    ifu_rresp  = 2'b10;
                end
                if (own_rready) begin
                    last_d  = owner_q;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                s_rready = 1'b1;
                if (s_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with TIMEOUT=4; expectations are hand-derived.
module tb_axi_read_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b0;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready = 1'b0;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;
    logic        s_rvalid = 1'b0;
    logic        s_rready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    axi_read_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // From IDLE with the request already driven: grant, one AR wait cycle, AR, one R beat.
    task automatic do_read(input bit who, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input bit hold);
        tick();
        chk("ar_valid", 32'(s_arvalid), 32'd1);
        chk("ar_addr", s_araddr, addr);
        chk("ar_wait", 32'(who ? lsu_arready : ifu_arready), 32'd0);
        tick();
        s_arready = 1'b1;
        #1;
        chk("ar_held", 32'(s_arvalid), 32'd1);
        chk("grant", 32'(who ? lsu_arready : ifu_arready), 32'd1);
        chk("grant_other", 32'(who ? ifu_arready : lsu_arready), 32'd0);
        tick();
        s_arready = 1'b0;
        if (!hold) begin
            if (who) lsu_arvalid = 1'b0;
            else     ifu_arvalid = 1'b0;
        end
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_rresp  = resp;
        if (who) lsu_rready = 1'b1;
        else     ifu_rready = 1'b1;
        #1;
        chk("ar_overlap", 32'(s_arvalid), 32'd0);
        chk("r_valid", 32'(who ? lsu_rvalid : ifu_rvalid), 32'd1);
        chk("r_data", who ? lsu_rdata : ifu_rdata, data);
        chk("r_resp", 32'(who ? lsu_rresp : ifu_rresp), 32'(resp));
        chk("r_other", 32'(who ? ifu_rvalid : lsu_rvalid), 32'd0);
        chk("s_rready", 32'(s_rready), 32'd1);
        tick();
        s_rvalid   = 1'b0;
        lsu_rready = 1'b0;
        ifu_rready = 1'b0;
        #1;
        chk("idle_arvalid", 32'(s_arvalid), 32'd0);
        chk("idle_rready", 32'(s_rready), 32'd0);
        chk("idle_rvalid", 32'(ifu_rvalid | lsu_rvalid), 32'd0);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_s_arvalid", 32'(s_arvalid), 32'd0);
        chk("rst_s_rready", 32'(s_rready), 32'd0);
        chk("rst_s_araddr", s_araddr, 32'd0);
        chk("rst_rvalid", 32'(ifu_rvalid | lsu_rvalid), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // single IFU read; one cycle of request latency
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        #1;
        chk("latency", 32'(s_arvalid), 32'd0);
        do_read(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00, 1'b0);

        // back-pressure: 2 empty DATA cycles, then 5 cycles of stalled beat, TIMEOUT=4
        lsu_araddr  = 32'h8000_1000;
        lsu_arvalid = 1'b1;
        tick();
        s_arready = 1'b1;
        tick();
        s_arready   = 1'b0;
        lsu_arvalid = 1'b0;
        tick();
        tick();
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFE_F00D;
        s_rresp  = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rvalid", 32'(lsu_rvalid), 32'd1);
            chk("bp_rresp", 32'(lsu_rresp), 32'd0);
            chk("bp_s_rready", 32'(s_rready), 32'd0);
            tick();
        end
        lsu_rready = 1'b1;
        #1;
        chk("bp_rdata", lsu_rdata, 32'hCAFE_F00D);
        chk("bp_s_rready_up", 32'(s_rready), 32'd1);
        tick();
        s_rvalid   = 1'b0;
        lsu_rready = 1'b0;
        #1;
        chk("bp_done", 32'(lsu_rvalid), 32'd0);

        // timeout on an IFU read, then drain of the late beat
        ifu_araddr  = 32'h8000_0040;
        ifu_arvalid = 1'b1;
        tick();
        s_arready = 1'b1;
        tick();
        s_arready   = 1'b0;
        ifu_arvalid = 1'b0;
        s_rdata     = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_early", 32'(ifu_rvalid), 32'd0);
        end
        tick();
        chk("to_rvalid", 32'(ifu_rvalid), 32'd1);
        chk("to_rresp", 32'(ifu_rresp), 32'd2);
        chk("to_rdata", ifu_rdata, 32'd0);
        chk("to_s_rready", 32'(s_rready), 32'd0);
        ifu_araddr  = 32'h8000_0080;
        ifu_arvalid = 1'b1;
        ifu_rready  = 1'b1;
        tick();
        ifu_rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("drain_s_rready", 32'(s_rready), 32'd1);
            chk("drain_no_grant", 32'(s_arvalid | ifu_arready), 32'd0);
            chk("drain_rvalid", 32'(ifu_rvalid | lsu_rvalid), 32'd0);
            tick();
        end
        s_rvalid = 1'b1;
        s_rdata  = 32'hBAD0_BAD0;
        #1;
        chk("drain_swallow", 32'(ifu_rvalid), 32'd0);
        tick();
        s_rvalid = 1'b0;
        #1;
        chk("post_drain_idle", 32'(s_arvalid | s_rready), 32'd0);
        do_read(1'b0, 32'h8000_0080, 32'h1111_2222, 2'b00, 1'b0);

        // slave error passthrough
        lsu_araddr  = 32'h8000_2000;
        lsu_arvalid = 1'b1;
        do_read(1'b1, 32'h8000_2000, 32'h0BAD_F00D, 2'b11, 1'b0);

        // async reset while in DATA
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        tick();
        s_arready = 1'b1;
        tick();
        s_arready  = 1'b0;
        s_rvalid   = 1'b1;
        s_rdata    = 32'h5555_AAAA;
        ifu_rready = 1'b1;
        #1;
        chk("pre_rst_rvalid", 32'(ifu_rvalid), 32'd1);
        chk("pre_rst_s_rready", 32'(s_rready), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_s_rready", 32'(s_rready), 32'd0);
        chk("arst_s_arvalid", 32'(s_arvalid), 32'd0);
        chk("arst_rvalid", 32'(ifu_rvalid | lsu_rvalid), 32'd0);
        chk("arst_arready", 32'(ifu_arready | lsu_arready), 32'd0);
        s_rvalid   = 1'b0;
        ifu_rready = 1'b0;
        tick();
        reset = 1'b1;

        // three tied rounds after reset: IFU, LSU, IFU
        ifu_araddr  = 32'h8000_0000;
        lsu_araddr  = 32'h8000_1000;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        do_read(1'b0, 32'h8000_0000, 32'hA000_0001, 2'b00, 1'b1);
        do_read(1'b1, 32'h8000_1000, 32'hA000_0002, 2'b00, 1'b1);
        do_read(1'b0, 32'h8000_0000, 32'hA000_0003, 2'b00, 1'b1);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
